// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the register file slice.
//   reg_addr_t / reg_data_t : address and data types at the default
//                             32-entry, 64-bit configuration
//   ZERO_IDX                : index of the hardwired zero register
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int ZERO_IDX  = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// regfile_busy_tracker: per-register pending-write flags with popcount.
//   clk, rst           : clock, synchronous active-high reset
//   iss_en, iss_addr   : issue marks a destination busy
//   wr_en, wr_addr     : writeback clears the destination busy bit
//   flush              : clears every busy bit
//   busy               : registered busy vector, one bit per register
//   busy_cnt           : number of set busy bits
// Busy-bit priority: rst > flush > issue > writeback.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                // A same-cycle issue means a newer producer owns the register.
                if (iss_en && iss_addr == AW'(i))
                    busy[i] <= 1'b1;
                else if (wr_en && wr_addr == AW'(i))
                    busy[i] <= 1'b0;
            end
            if (ZERO_REG != 0)
                busy[ZERO_IDX] <= 1'b0;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NREGS; i++)
            busy_cnt = busy_cnt + (AW+1)'(busy[i]);
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with busy-bit scoreboard.
//   clk, rst                   : clock, synchronous active-high reset
//   rd_addr/rd_data/rd_busy    : NREAD combinational read ports
//   wr_en/wr_addr/wr_data      : clocked writeback port
//   iss_en/iss_addr            : issue, marks destination pending
//   flush                      : clears all pending flags
//   busy_cnt                   : count of pending registers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NREGS      = 32,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1,
    parameter int AW         = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREAD-1:0][AW-1:0]    rd_addr,
    output logic [NREAD-1:0][XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]            rd_busy,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [XLEN-1:0]             wr_data,
    input  logic                        iss_en,
    input  logic [AW-1:0]               iss_addr,
    input  logic                        flush,
    output logic [AW:0]                 busy_cnt
);

    logic [NREGS-1:0][XLEN-1:0] data;
    logic [NREGS-1:0]           busy;
    logic                       wr_zero;
    logic                       iss_ok;

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == AW'(ZERO_IDX));
    // Issues to the zero register are dropped before reaching the tracker.
    assign iss_ok  = iss_en && !((ZERO_REG != 0) && (iss_addr == AW'(ZERO_IDX)));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                data[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
        end else if (wr_en && !wr_zero) begin
            data[wr_addr] <= wr_data;
        end
    end

    regfile_busy_tracker #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_ok),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic is_zero;
        logic hit;
        assign is_zero    = (ZERO_REG != 0) && (rd_addr[p] == AW'(ZERO_IDX));
        // Forward the in-flight writeback; issue is deliberately not forwarded.
        assign hit        = (BYPASS != 0) && wr_en && (wr_addr == rd_addr[p]) && !is_zero;
        assign rd_data[p] = is_zero ? '0 : (hit ? wr_data : data[rd_addr[p]]);
        assign rd_busy[p] = is_zero ? 1'b0 : (hit ? 1'b0 : busy[rd_addr[p]]);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][4:0] rd_addr;
    logic [1:0][63:0] rd_data, nz_rd_data;
    logic [1:0]      rd_busy, nz_rd_busy;
    logic            wr_en, iss_en, flush;
    logic [4:0]      wr_addr, iss_addr;
    logic [63:0]     wr_data;
    logic [5:0]      busy_cnt, nz_busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Default configuration (ZERO_REG=1)
    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    // Same inputs, ordinary register 0
    regfile_scoreboard #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nz_rd_data), .rd_busy(nz_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(nz_busy_cnt)
    );

    // Reference model: k=0 zero-register config, k=1 plain config
    logic [63:0] m_data [2][32];
    bit          m_busy [2][32];
    bit          chk_on = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_data[k][i] = 64'(i);
                    m_busy[k][i] = 0;
                end
            end else begin
                if (wr_en && !(k == 0 && wr_addr == 0)) m_data[k][wr_addr] = wr_data;
                if (flush) begin
                    for (int i = 0; i < 32; i++) m_busy[k][i] = 0;
                end else begin
                    if (wr_en)  m_busy[k][wr_addr] = 0;
                    if (iss_en) m_busy[k][iss_addr] = 1;
                end
                if (k == 0) m_busy[k][0] = 0;
            end
        end
        if (rst) chk_on = 1;
    end

    function automatic logic [64:0] model_rd(int k, logic [4:0] a);
        if (k == 0 && a == 0) return '0;
        if (wr_en && wr_addr == a) return {1'b0, wr_data};
        return {m_busy[k][a], m_data[k][a]};
    endfunction

    function automatic int model_cnt(int k);
        int s = 0;
        for (int i = 0; i < 32; i++) s += int'(m_busy[k][i]);
        return s;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    logic [64:0] e;
                    e = model_rd(k, rd_addr[p]);
                    chk($sformatf("model rd_data k%0d p%0d", k, p),
                        k == 0 ? rd_data[p] : nz_rd_data[p], e[63:0]);
                    chk($sformatf("model rd_busy k%0d p%0d", k, p),
                        64'(k == 0 ? rd_busy[p] : nz_rd_busy[p]), 64'(e[64]));
                end
                chk($sformatf("model busy_cnt k%0d", k),
                    64'(k == 0 ? busy_cnt : nz_busy_cnt), 64'(model_cnt(k)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 0; wr_en = 0; iss_en = 0; flush = 0;
    endtask

    initial begin
        rst = 1; wr_en = 0; iss_en = 0; flush = 0;
        wr_addr = 0; iss_addr = 0; wr_data = 0;
        rd_addr[0] = 5; rd_addr[1] = 31;
        tick();
        @(negedge clk);
        chk("reset rd5", rd_data[0], 64'd5);
        chk("reset rd31", rd_data[1], 64'd31);
        chk("reset busy", 64'(rd_busy), 64'd0);
        chk("reset cnt", 64'(busy_cnt), 64'd0);

        // issue 7, idle, writeback 7
        iss_en = 1; iss_addr = 7; rd_addr[0] = 7;
        tick();
        @(negedge clk);
        chk("iss7 busy", 64'(rd_busy[0]), 64'd1);
        chk("iss7 cnt", 64'(busy_cnt), 64'd1);
        wr_en = 1; wr_addr = 7; wr_data = 64'hDEAD_BEEF;
        @(negedge clk);
        chk("wb7 bypass data", rd_data[0], 64'hDEAD_BEEF);
        chk("wb7 bypass busy", 64'(rd_busy[0]), 64'd0);
        tick();
        @(negedge clk);
        chk("wb7 array data", rd_data[0], 64'hDEAD_BEEF);
        chk("wb7 cnt", 64'(busy_cnt), 64'd0);

        // issue + writeback to 3 together
        iss_en = 1; iss_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 64'hABCD; rd_addr[1] = 3;
        tick();
        @(negedge clk);
        chk("iss+wb3 data", rd_data[1], 64'hABCD);
        chk("iss+wb3 busy", 64'(rd_busy[1]), 64'd1);
        chk("iss+wb3 cnt", 64'(busy_cnt), 64'd1);
        wr_en = 1; wr_addr = 3; wr_data = 64'hABCD;
        tick();

        // register 0
        wr_en = 1; wr_addr = 0; wr_data = 64'h1234; iss_en = 1; iss_addr = 0; rd_addr[0] = 0;
        @(negedge clk);
        chk("r0 same-cycle zr", rd_data[0], 64'd0);
        chk("r0 same-cycle nz", nz_rd_data[0], 64'h1234);
        tick();
        @(negedge clk);
        chk("r0 zr data", rd_data[0], 64'd0);
        chk("r0 zr busy", 64'(rd_busy[0]), 64'd0);
        chk("r0 zr cnt", 64'(busy_cnt), 64'd0);
        chk("r0 nz data", nz_rd_data[0], 64'h1234);
        chk("r0 nz busy", 64'(nz_rd_busy[0]), 64'd1);
        wr_en = 1; wr_addr = 0; wr_data = 64'h1234;
        tick();

        // issue 1,2,4 then flush with writeback to 2
        iss_en = 1; iss_addr = 1; rd_addr[1] = 2;
        tick();
        iss_en = 1; iss_addr = 2;
        tick();
        iss_en = 1; iss_addr = 4;
        tick();
        flush = 1; wr_en = 1; wr_addr = 2; wr_data = 64'h55;
        @(negedge clk);
        chk("pre-flush cnt", 64'(busy_cnt), 64'd3);
        chk("pre-flush nz cnt", 64'(nz_busy_cnt), 64'd3);
        tick();
        @(negedge clk);
        chk("flush cnt", 64'(busy_cnt), 64'd0);
        chk("flush r2 data", rd_data[1], 64'h55);

        // reset overrides writeback and issue
        rst = 1; wr_en = 1; wr_addr = 9; wr_data = 64'hFFFF; iss_en = 1; iss_addr = 10;
        rd_addr[0] = 9; rd_addr[1] = 10;
        tick();
        @(negedge clk);
        chk("rst r9 data", rd_data[0], 64'd9);
        chk("rst r10 busy", 64'(rd_busy[1]), 64'd0);
        chk("rst cnt", 64'(busy_cnt), 64'd0);

        // randomized traffic, model compare runs every cycle
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = ($urandom_range(0, 2) != 0);
            iss_en   = ($urandom_range(0, 1) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            wr_addr  = 5'($urandom_range(0, 31));
            iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            wr_data  = {$urandom, $urandom};
            rd_addr[0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr[1] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        end
        tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file with a built-in busy-bit scoreboard for the pipelined datapath. It provides NREAD combinational read ports, one clocked writeback port, and an optional write-to-read bypass. Each register carries a pending-write flag that is set at instruction issue and cleared at writeback, so decode can detect RAW hazards without a separate unit. It replaces the fixed 2-read, 64-bit, 32-entry bank used in the single-cycle core.

## Interface
Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to matching read ports
- INIT_INDEX, 1, when 1 reset loads register i with value i; when 0 reset loads 0

Ports (AW = $clog2(NREGS)):
- Clocking: one clock; reset is synchronous and active-high.
- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous active-high reset
- rd_addr, input, NREAD×AW, read addresses
- rd_data, output, NREAD×XLEN, read data (combinational)
- rd_busy, output, NREAD, pending-write flag of each addressed register (combinational)
- wr_en, input, 1, writeback strobe
- wr_addr, input, AW, writeback destination
- wr_data, input, XLEN, writeback value
- iss_en, input, 1, issue strobe: marks a destination as pending
- iss_addr, input, AW, issued destination
- flush, input, 1, clears all busy bits (pipeline squash)
- busy_cnt, output, AW+1, number of registers currently busy

## Operation
- Data array: `data[i]`, XLEN bits. Busy array: `busy[i]`, 1 bit.
- On reset: `data[i]` is loaded with i (zero-extended) if INIT_INDEX=1, otherwise 0. All `busy[i]` are cleared, so `busy_cnt` = 0. With ZERO_REG=1, `data[0]` = 0 in both cases.
- Writeback: when `wr_en` is high, `data[wr_addr] <= wr_data` and `busy[wr_addr] <= 0`.
- Issue: when `iss_en` is high, `busy[iss_addr] <= 1`.
- Flush: when `flush` is high, all busy bits are cleared. A writeback in the same cycle still updates data.
- Priority for a busy bit, highest first: rst, then flush, then iss_en, then wr_en.
  - Issue and writeback to the same register in the same cycle leaves busy = 1, because the new producer wins.
  - Flush together with issue leaves busy = 0.
- Register 0 when ZERO_REG=1:
  - Writes to it are dropped.
  - Issue to it is ignored.
  - Reads return 0 with busy = 0.
- Read, for each port p:
  - If BYPASS=1, `wr_en`=1, `wr_addr==rd_addr[p]` and the address is not the zero register: `rd_data[p]=wr_data` and `rd_busy[p]=0`.
  - Otherwise: `rd_data[p]=data[rd_addr[p]]` and `rd_busy[p]=busy[rd_addr[p]]`.
- Issue never affects the same-cycle read value or read busy flag.
- `busy_cnt` is the population count of the registered busy array. It is 0 to NREGS, or 0 to NREGS−1 when ZERO_REG=1.
- There is no overflow check. Issuing an already-busy register keeps it busy, and the count is unchanged.

## Timing
- Read latency: 0 cycles (combinational from `rd_addr` and register state).
- Write latency: 1 cycle. Data written at edge N is visible without bypass from cycle N+1.
- With BYPASS=1, `wr_data` appears on a matching read port in the same cycle as `wr_en`.
- Busy set/clear takes effect after the edge. `busy_cnt` reflects the state after the edge.
- Reset mid-operation: concurrent `wr_en` and `iss_en` are ignored in the reset cycle. All state takes reset values at that edge.
- There is no backpressure or handshake. The producer guarantees at most one issue and one writeback per cycle.

## Structure
- Package `regfile_pkg`: the typedefs `reg_addr_t` and `reg_data_t` built from the parameters' defaults, and a constant for the zero-register index.
- Sub-module `regfile_busy_tracker` holds the busy array, the set/clear/flush priority and the popcount. The top level holds the data array, read muxes and bypass.
- Reads use a generate loop over NREAD.

## Test plan
- Reset with INIT_INDEX=1 and XLEN=64. Read registers 5 and 31 → `rd_data` = 5 and 31, `rd_busy` = 0, `busy_cnt` = 0.
- Issue register 7, then write back 0xDEAD_BEEF to register 7 one cycle later.
  - Cycle after issue: `rd_busy` = 1, `busy_cnt` = 1.
  - Writeback cycle: the read returns 0xDEAD_BEEF with busy 0 through the bypass.
  - Next cycle: the same value comes from the array and `busy_cnt` = 0.
- Issue and writeback to register 3 in the same cycle → register 3 is busy afterwards, holds the new data, and `busy_cnt` = 1.
- Write 0x1234 to register 0 and issue register 0 (ZERO_REG=1) → reads return 0 with busy 0. With ZERO_REG=0 the same write reads back 0x1234.
- Issue registers 1, 2 and 4, then assert `flush` together with a writeback of 0x55 to register 2 → `busy_cnt` = 0 and register 2 reads 0x55.
- Assert `rst` in a cycle with `wr_en` to register 9 and `iss_en` to register 10 → register 9 reads 9, register 10 is not busy, and `busy_cnt` = 0.
